// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit and the data memory.
// The unit drives the request side; the memory returns a single-cycle ack with read data.
interface mem_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM load/store controls into one req/ack transaction,
// stalls the pipeline until it completes, and flags misaligned accesses and timeouts.
module mem_access_unit #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEMR_IN,
    input  logic              MEMW_IN,
    input  logic [DATA_W-1:0] ALU_C_IN,
    input  logic [DATA_W-1:0] RT_DATA_IN,
    mem_access_unit_if.master dmem,
    output logic              mem_stall,
    output logic [DATA_W-1:0] MEM_RDATA_OUT,
    output logic              misalign_err,
    output logic              timeout_err
);
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [DATA_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              misalign_reg, misalign_next;
    logic              timeout_reg, timeout_next;

    logic op;
    logic aligned;

    assign op      = MEMR_IN | MEMW_IN;
    assign aligned = (ALU_C_IN[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            req_reg      <= req_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            misalign_reg <= misalign_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        req_next      = req_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        misalign_next = 1'b0;
        timeout_next  = timeout_reg;

        case (state_reg)
            IDLE: begin
                if (op) begin
                    if (aligned) begin
                        addr_next  = ALU_C_IN;
                        wdata_next = RT_DATA_IN;
                        we_next    = MEMW_IN;
                        req_next   = 1'b1;
                        cnt_next   = '0;
                        state_next = BUSY;
                    end else begin
                        misalign_next = 1'b1;
                    end
                end
            end
            BUSY: begin
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (dmem.dmem_ack) begin
                    req_next = 1'b0;
                    if (!we_reg) begin
                        rdata_next = dmem.dmem_rdata;
                    end
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    req_next     = 1'b0;
                    timeout_next = 1'b1;
                    if (!we_reg) begin
                        rdata_next = '0;
                    end
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                // The op still visible here is the instruction that just finished.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stall is raised in the issue cycle itself so EX/MEM holds the op while it is latched.
    assign mem_stall = rst & (((state_reg == IDLE) & op & aligned) | (state_reg == BUSY));

    assign dmem.dmem_req   = req_reg;
    assign dmem.dmem_we    = we_reg;
    assign dmem.dmem_addr  = addr_reg;
    assign dmem.dmem_wdata = wdata_reg;

    assign MEM_RDATA_OUT = rdata_reg;
    assign misalign_err  = misalign_reg;
    assign timeout_err   = timeout_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: each access pushes its expected outcome to a scoreboard,
// which is popped and compared when the DUT reaches its DONE cycle.
module tb_mem_access_unit;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              MEMR_IN = 1'b0;
    logic              MEMW_IN = 1'b0;
    logic [DATA_W-1:0] ALU_C_IN = '0;
    logic [DATA_W-1:0] RT_DATA_IN = '0;
    logic              mem_stall;
    logic [DATA_W-1:0] MEM_RDATA_OUT;
    logic              misalign_err;
    logic              timeout_err;

    mem_access_unit_if #(.DATA_W(DATA_W)) dif ();

    mem_access_unit #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .MEMR_IN       (MEMR_IN),
        .MEMW_IN       (MEMW_IN),
        .ALU_C_IN      (ALU_C_IN),
        .RT_DATA_IN    (RT_DATA_IN),
        .dmem          (dif.master),
        .mem_stall     (mem_stall),
        .MEM_RDATA_OUT (MEM_RDATA_OUT),
        .misalign_err  (misalign_err),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_out;
        int          stall;
        logic        timeout;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rdata_model   = '0;
    logic        timeout_model = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_op();
        @(posedge clk); #1;
        MEMR_IN = 1'b0;
        MEMW_IN = 1'b0;
        dif.dmem_ack = 1'b0;
    endtask

    // ack_at = BUSY cycle (1-based) carrying the ack; 0 means never ack.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_at);
        exp_t e;
        exp_t got;
        int   stall_n;
        logic done_seen;
        logic acked;
        acked       = (ack_at > 0) && (ack_at <= MAX_WAIT);
        e.we        = wr;
        e.addr      = addr;
        e.wdata     = wdata;
        e.stall     = acked ? ack_at + 1 : MAX_WAIT + 1;
        e.rdata_out = wr ? rdata_model : (acked ? rdata : 32'h0);
        e.timeout   = timeout_model | !acked;
        rdata_model   = e.rdata_out;
        timeout_model = e.timeout;
        sb.push_back(e);

        @(posedge clk); #1;
        MEMR_IN    = rd;
        MEMW_IN    = wr;
        ALU_C_IN   = addr;
        RT_DATA_IN = wdata;
        dif.dmem_ack = 1'b0;
        stall_n   = 0;
        done_seen = 1'b0;
        for (int j = 0; j < MAX_WAIT + 8 && !done_seen; j++) begin
            @(negedge clk);
            if (mem_stall) stall_n++;
            if (j == 0) begin
                check({tag, "_issue_stall"}, mem_stall, 1'b1);
                check({tag, "_issue_noreq"}, dif.dmem_req, 1'b0);
            end else if (mem_stall) begin
                check({tag, "_req"},   dif.dmem_req,   1'b1);
                check({tag, "_we"},    dif.dmem_we,    e.we);
                check({tag, "_addr"},  dif.dmem_addr,  e.addr);
                check({tag, "_wdata"}, dif.dmem_wdata, e.wdata);
            end else begin
                done_seen = 1'b1;
                got = sb.pop_front();
                check({tag, "_stall_cycles"}, 32'(stall_n), 32'(got.stall));
                check({tag, "_done_noreq"},   dif.dmem_req, 1'b0);
                check({tag, "_rdata_out"},    MEM_RDATA_OUT, got.rdata_out);
                check({tag, "_timeout"},      timeout_err, got.timeout);
                check({tag, "_misalign"},     misalign_err, 1'b0);
                $display("txn %s we=%0b addr=%h rdata_out=%h stall=%0d timeout=%0b",
                         tag, got.we, got.addr, MEM_RDATA_OUT, stall_n, timeout_err);
            end
            if (!done_seen) begin
                @(posedge clk); #1;
                dif.dmem_ack   = (j + 1 == ack_at);
                dif.dmem_rdata = (j + 1 == ack_at) ? rdata : (32'hBAD0_0000 | 32'(j));
            end
        end
        check({tag, "_completed"}, done_seen, 1'b1);
    endtask

    task automatic misalign_access(input string tag, input logic [31:0] addr);
        @(posedge clk); #1;
        MEMR_IN  = 1'b1;
        ALU_C_IN = addr;
        @(negedge clk);
        check({tag, "_nostall"}, mem_stall, 1'b0);
        check({tag, "_noreq"},   dif.dmem_req, 1'b0);
        @(posedge clk); #1;
        MEMR_IN = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"},   misalign_err, 1'b1);
        check({tag, "_noreq2"},  dif.dmem_req, 1'b0);
        @(negedge clk);
        check({tag, "_pulse_end"}, misalign_err, 1'b0);
        check({tag, "_rdata_kept"}, MEM_RDATA_OUT, rdata_model);
        $display("txn %s misaligned addr=%h", tag, addr);
    endtask

    task automatic stray_ack(input string tag);
        @(posedge clk); #1;
        dif.dmem_ack   = 1'b1;
        dif.dmem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        check({tag, "_nostall"}, mem_stall, 1'b0);
        @(posedge clk); #1;
        dif.dmem_ack = 1'b0;
        @(negedge clk);
        check({tag, "_noreq"},      dif.dmem_req, 1'b0);
        check({tag, "_rdata_kept"}, MEM_RDATA_OUT, rdata_model);
        check({tag, "_nostall2"},   mem_stall, 1'b0);
        $display("txn %s stray ack in IDLE", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = '0;
        MEMR_IN = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall",    mem_stall, 1'b0);
        check("rst_req",      dif.dmem_req, 1'b0);
        check("rst_rdata",    MEM_RDATA_OUT, 32'h0);
        check("rst_timeout",  timeout_err, 1'b0);
        MEMR_IN = 1'b0;
        rst = 1'b1;

        run_access("ld40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1);
        run_access("st80", 1'b0, 1'b1, 32'h80, 32'h12345678, 32'hAAAA5555, 5);
        clear_op();
        misalign_access("ld42", 32'h42);
        run_access("ld_to", 1'b1, 1'b0, 32'h44, 32'h0, 32'h13579BDF, 0);
        clear_op();
        run_access("ld_after", 1'b1, 1'b0, 32'h48, 32'h0, 32'hCAFEF00D, 3);
        clear_op();
        run_access("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 32'h11111111, 2);
        run_access("ld14", 1'b1, 1'b0, 32'h14, 32'h0, 32'h22222222, 1);
        clear_op();
        stray_ack("idle_ack");
        run_access("ld_ack16", 1'b1, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, MAX_WAIT);
        run_access("rdwr", 1'b1, 1'b1, 32'h24, 32'h5A5A5A5A, 32'h77777777, 2);
        clear_op();

        // Reset in the middle of a BUSY access with the load still presented.
        @(posedge clk); #1;
        MEMR_IN  = 1'b1;
        ALU_C_IN = 32'h100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_req_before", dif.dmem_req, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_req",      dif.dmem_req, 1'b0);
        check("mid_rst_stall",    mem_stall, 1'b0);
        check("mid_rst_we",       dif.dmem_we, 1'b0);
        check("mid_rst_addr",     dif.dmem_addr, 32'h0);
        check("mid_rst_wdata",    dif.dmem_wdata, 32'h0);
        check("mid_rst_rdata",    MEM_RDATA_OUT, 32'h0);
        check("mid_rst_timeout",  timeout_err, 1'b0);
        check("mid_rst_misalign", misalign_err, 1'b0);
        $display("txn mid_rst reset during BUSY");
        @(posedge clk); #1;
        MEMR_IN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rdata_model   = '0;
        timeout_model = 1'b0;
        run_access("ld_post_rst", 1'b1, 1'b0, 32'h104, 32'h0, 32'h600DF00D, 2);
        clear_op();
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
